// File: rtl/deserializer.sv
// Receive side of the start/enable/serial bit link: assembles MSB-first words and
// offers them on a valid/ready port, flagging aborted frames and dropped words.
module deserializer #(
    parameter int DATA_WIDTH  = 8,
    parameter int GAP_TIMEOUT = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  serial_in_i,
    input  logic                  enable_i,
    input  logic                  start_i,
    output logic [DATA_WIDTH-1:0] parallel_out_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  busy_o,
    output logic                  frame_err_o,
    output logic                  overflow_o
);

    localparam int CW = $clog2(DATA_WIDTH) + 1;
    localparam int GW = (GAP_TIMEOUT > 0) ? $clog2(GAP_TIMEOUT + 1) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e                state_q,     state_d;
    logic [DATA_WIDTH-1:0] shift_q,     shift_d;
    logic [CW-1:0]         count_q,     count_d;
    logic [GW-1:0]         gap_q,       gap_d;
    logic [DATA_WIDTH-1:0] data_q,      data_d;
    logic                  valid_q,     valid_d;
    logic                  frame_err_q, frame_err_d;
    logic                  overflow_q,  overflow_d;

    logic [DATA_WIDTH-1:0] shift_next;
    logic                  complete;

    assign shift_next = {shift_q[DATA_WIDTH-2:0], serial_in_i};

    // NOTE: every next-state signal is given a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        count_d     = count_q;
        gap_d       = gap_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overflow_d  = 1'b0;
        complete    = 1'b0;

        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (enable_i && start_i) begin
                    state_d = SHIFT;
                    shift_d = shift_next;
                    count_d = CW'(1);
                    gap_d   = '0;
                end
            end
            SHIFT: begin
                if (enable_i) begin
                    shift_d = shift_next;
                    gap_d   = '0;
                    if (start_i) begin
                        frame_err_d = 1'b1;
                        count_d     = CW'(1);
                    end else if (count_q == CW'(DATA_WIDTH - 1)) begin
                        complete = 1'b1;
                        state_d  = IDLE;
                        count_d  = '0;
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end else if (GAP_TIMEOUT != 0) begin
                    // Gap counting only matters when a timeout is configured.
                    if (gap_q == GW'(GAP_TIMEOUT - 1)) begin
                        frame_err_d = 1'b1;
                        state_d     = IDLE;
                        count_d     = '0;
                        gap_d       = '0;
                    end else begin
                        gap_d = gap_q + GW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A finished word is only dropped when the held one is still unconsumed.
        if (complete) begin
            if (!valid_q || ready_i) begin
                data_d  = shift_next;
                valid_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update
    // together from values sampled at the same edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            count_q     <= '0;
            gap_q       <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            count_q     <= count_d;
            gap_q       <= gap_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

    assign parallel_out_o = data_q;
    assign valid_o        = valid_q;
    assign busy_o         = (state_q == SHIFT);
    assign frame_err_o    = frame_err_q;
    assign overflow_o     = overflow_q;

endmodule

// File: tb/tb_deserializer.sv
// Directed bench for deserializer: one timeout-enabled instance under full check,
// plus a no-timeout instance on the same inputs for the gap comparison.
module tb_deserializer;

    logic       clk_i;
    logic       rst_i;
    logic       serial_in_i;
    logic       enable_i;
    logic       start_i;
    logic       ready_i;

    logic [7:0] pout4, pout0;
    logic       valid4, valid0;
    logic       busy4, busy0;
    logic       fe4, fe0;
    logic       ov4, ov0;

    int total = 0;
    int bad   = 0;

    int         rx_cnt = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    logic [7:0] rx_words [0:63];

    deserializer #(.DATA_WIDTH(8), .GAP_TIMEOUT(4)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .serial_in_i    (serial_in_i),
        .enable_i       (enable_i),
        .start_i        (start_i),
        .parallel_out_o (pout4),
        .valid_o        (valid4),
        .ready_i        (ready_i),
        .busy_o         (busy4),
        .frame_err_o    (fe4),
        .overflow_o     (ov4)
    );

    deserializer #(.DATA_WIDTH(8), .GAP_TIMEOUT(0)) dut_nogap (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .serial_in_i    (serial_in_i),
        .enable_i       (enable_i),
        .start_i        (start_i),
        .parallel_out_o (pout0),
        .valid_o        (valid0),
        .ready_i        (ready_i),
        .busy_o         (busy0),
        .frame_err_o    (fe0),
        .overflow_o     (ov0)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Records every handshake and error pulse on the timeout instance.
    always @(negedge clk_i) begin
        if (valid4 && ready_i && !rst_i) begin
            if (rx_cnt < 64) rx_words[rx_cnt] = pout4;
            rx_cnt++;
        end
        if (fe4) fe_cnt++;
        if (ov4) ov_cnt++;
    end

    task automatic idle();
        @(negedge clk_i);
        enable_i    = 1'b0;
        start_i     = 1'b0;
        serial_in_i = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] bits, input int n, input bit with_start);
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge clk_i);
            enable_i    = 1'b1;
            start_i     = with_start && (i == n - 1);
            serial_in_i = bits[i];
        end
    endtask

    task automatic send_word(input logic [7:0] w);
        send_bits(w, 8, 1'b1);
    endtask

    task automatic check_all_zero(input string name);
        total++;
        if ({pout4, valid4, busy4, fe4, ov4} !== 12'h000) begin
            bad++;
            $display("FAIL %s: out=%h valid=%b busy=%b fe=%b ov=%b, want all 0",
                     name, pout4, valid4, busy4, fe4, ov4);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; enable_i = 1'b0; start_i = 1'b0; serial_in_i = 1'b0; ready_i = 1'b1;
        repeat (3) @(negedge clk_i);
        check_all_zero("reset_state");
        rst_i = 1'b0;
    endtask

    task automatic test_single();
        send_bits(8'b1010_0101, 8, 1'b1);
        idle();
        total++;
        if (valid4 !== 1'b1 || pout4 !== 8'hA5) begin
            bad++;
            $display("FAIL single_load: valid=%b out=%h, want 1 a5", valid4, pout4);
        end
        @(negedge clk_i);
        total++;
        if (valid4 !== 1'b0 || pout4 !== 8'hA5 || busy4 !== 1'b0) begin
            bad++;
            $display("FAIL single_drop: valid=%b out=%h busy=%b, want 0 a5 0", valid4, pout4, busy4);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_w [0:2];
        int rx_base, fe_base, ov_base;
        exp_w[0] = 8'h3C; exp_w[1] = 8'hFF; exp_w[2] = 8'h00;
        rx_base = rx_cnt; fe_base = fe_cnt; ov_base = ov_cnt;
        for (int k = 0; k < 3; k++) send_word(exp_w[k]);
        idle();
        repeat (2) @(negedge clk_i);
        total++;
        if (rx_cnt - rx_base !== 3) begin
            bad++;
            $display("FAIL b2b_count: got %0d words, want 3", rx_cnt - rx_base);
        end
        for (int k = 0; k < 3; k++) begin
            total++;
            if (rx_words[rx_base + k] !== exp_w[k]) begin
                bad++;
                $display("FAIL b2b_word%0d: got %h, want %h", k, rx_words[rx_base + k], exp_w[k]);
            end
        end
        total++;
        if (fe_cnt - fe_base !== 0 || ov_cnt - ov_base !== 0) begin
            bad++;
            $display("FAIL b2b_errors: fe=%0d ov=%0d, want 0 0", fe_cnt - fe_base, ov_cnt - ov_base);
        end
    endtask

    task automatic test_overflow();
        ready_i = 1'b0;
        send_word(8'h11);
        idle();
        total++;
        if (valid4 !== 1'b1 || pout4 !== 8'h11) begin
            bad++;
            $display("FAIL ovf_first: valid=%b out=%h, want 1 11", valid4, pout4);
        end
        send_word(8'h22);
        idle();
        total++;
        if (ov4 !== 1'b1 || pout4 !== 8'h11 || valid4 !== 1'b1) begin
            bad++;
            $display("FAIL ovf_pulse: ov=%b out=%h valid=%b, want 1 11 1", ov4, pout4, valid4);
        end
        @(negedge clk_i);
        total++;
        if (ov4 !== 1'b0 || pout4 !== 8'h11) begin
            bad++;
            $display("FAIL ovf_once: ov=%b out=%h, want 0 11", ov4, pout4);
        end
        ready_i = 1'b1;
        @(negedge clk_i);
        total++;
        if (valid4 !== 1'b0 || pout4 !== 8'h11) begin
            bad++;
            $display("FAIL ovf_drain: valid=%b out=%h, want 0 11", valid4, pout4);
        end
    endtask

    task automatic test_restart();
        int fe_base, ov_base;
        @(negedge clk_i);
        fe_base = fe_cnt; ov_base = ov_cnt;
        send_bits(8'b0000_0111, 3, 1'b1);
        send_word(8'h5A);
        idle();
        total++;
        if (valid4 !== 1'b1 || pout4 !== 8'h5A) begin
            bad++;
            $display("FAIL restart_word: valid=%b out=%h, want 1 5a", valid4, pout4);
        end
        @(negedge clk_i);
        total++;
        if (fe_cnt - fe_base !== 1 || ov_cnt - ov_base !== 0) begin
            bad++;
            $display("FAIL restart_errs: fe=%0d ov=%0d, want 1 0", fe_cnt - fe_base, ov_cnt - ov_base);
        end
    endtask

    task automatic test_gap_timeout();
        int fe_base, rx_base;
        @(negedge clk_i);
        fe_base = fe_cnt; rx_base = rx_cnt;
        send_bits(8'b0000_0101, 3, 1'b1);
        idle();
        repeat (3) @(negedge clk_i);
        total++;
        if (busy4 !== 1'b1 || fe4 !== 1'b0) begin
            bad++;
            $display("FAIL gap_before: busy=%b fe=%b after 3 idle, want 1 0", busy4, fe4);
        end
        @(negedge clk_i);
        total++;
        if (fe4 !== 1'b1 || busy4 !== 1'b0 || valid4 !== 1'b0) begin
            bad++;
            $display("FAIL gap_abort: fe=%b busy=%b valid=%b, want 1 0 0", fe4, busy4, valid4);
        end
        total++;
        if (busy0 !== 1'b1 || fe0 !== 1'b0) begin
            bad++;
            $display("FAIL gap_none: busy=%b fe=%b on no-timeout unit, want 1 0", busy0, fe0);
        end
        send_bits(8'b0001_0011, 5, 1'b0);
        idle();
        total++;
        if (valid0 !== 1'b1 || pout0 !== 8'hB3) begin
            bad++;
            $display("FAIL gap_none_word: valid=%b out=%h, want 1 b3", valid0, pout0);
        end
        total++;
        if (valid4 !== 1'b0 || busy4 !== 1'b0) begin
            bad++;
            $display("FAIL gap_ignored: valid=%b busy=%b, want 0 0", valid4, busy4);
        end
        @(negedge clk_i);
        total++;
        if (fe_cnt - fe_base !== 1 || rx_cnt - rx_base !== 0) begin
            bad++;
            $display("FAIL gap_counts: fe=%0d rx=%0d, want 1 0", fe_cnt - fe_base, rx_cnt - rx_base);
        end
    endtask

    task automatic test_reset_midword();
        send_bits(8'b0000_1101, 4, 1'b1);
        @(negedge clk_i);
        rst_i = 1'b1; enable_i = 1'b1; start_i = 1'b0; serial_in_i = 1'b1;
        @(negedge clk_i);
        check_all_zero("reset_midword");
        rst_i = 1'b0; enable_i = 1'b0;
        ready_i = 1'b0;
        send_word(8'h77);
        idle();
        total++;
        if (valid4 !== 1'b1 || pout4 !== 8'h77) begin
            bad++;
            $display("FAIL reset_hold_pre: valid=%b out=%h, want 1 77", valid4, pout4);
        end
        rst_i = 1'b1;
        @(negedge clk_i);
        check_all_zero("reset_held_word");
        rst_i = 1'b0; ready_i = 1'b1;
        send_word(8'hC3);
        idle();
        total++;
        if (valid4 !== 1'b1 || pout4 !== 8'hC3 || fe4 !== 1'b0) begin
            bad++;
            $display("FAIL reset_after: valid=%b out=%h fe=%b, want 1 c3 0", valid4, pout4, fe4);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_restart();
        test_gap_timeout();
        test_reset_midword();
        repeat (2) @(negedge clk_i);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
